// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder resolving one 4-bit carry-lookahead slice per clock, low nibble first.
// Define NIBBLE_SERIAL_ADDER_OVF_EN to add the out_ovf signed-overflow output.
module nibble_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  output logic             out_ovf,
  output logic             out_co
`else
  output logic             out_co
`endif
);

  localparam int NIB = WIDTH / 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             out_co_q, out_co_d;
  logic             ovf_d;

  logic [3:0] nib_a, nib_b, g, p, c, nib_sum;
  logic       grp_g, grp_p, nib_co;

  // Operand registers shift right each RUN cycle so the active nibble is always bits [3:0].
  always_comb begin
    nib_a   = a_q[3:0];
    nib_b   = b_q[3:0];
    g       = nib_a & nib_b;
    p       = nib_a ^ nib_b;
    c[0]    = carry_q;
    c[1]    = g[0] | (p[0] & carry_q);
    c[2]    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    c[3]    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
    grp_g   = g[3] | (p[3] & (g[2] | (p[2] & (g[1] | (p[1] & g[0])))));
    grp_p   = p[3] & p[2] & p[1] & p[0];
    nib_co  = grp_g | (grp_p & carry_q);
    nib_sum = p ^ c;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    out_sum_d = out_sum_q;
    out_co_d  = out_co_q;
    ovf_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_ci;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        res_d   = (res_q >> 4) | (WIDTH'(nib_sum) << (WIDTH - 4));
        carry_d = nib_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NIB - 1)) begin
          out_sum_d = res_d;
          out_co_d  = nib_co;
          ovf_d     = c[3] ^ nib_co;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      out_sum_q <= '0;
      out_co_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      out_sum_q <= out_sum_d;
      out_co_q  <= out_co_d;
    end
  end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // Overflow is captured alongside the sum and held until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && cnt_q == CNT_W'(NIB - 1)) begin
      ovf_q <= ovf_d;
    end
  end

  assign out_ovf = ovf_q;
`else
  logic ovf_unused;
  assign ovf_unused = ovf_d;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = out_sum_q;
  assign out_co    = out_co_q;

endmodule
